// File: rtl/sram_axil_pkg.sv
// Shared constants, state encodings and address helpers for the AXI-lite SRAM responder.
package sram_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Held write-data beat (data plus byte enables)
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_payload_t;

    // Word index relative to the window base; addr[1:0] drops out
    function automatic logic [31:0] to_word_idx(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off >> 2;
    endfunction

    // True when addr lies in [base, base + 4*depth_words), computed in 33 bits to avoid wrap
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] depth_words);
        logic [32:0] off;
        logic [32:0] lim;
        off = {1'b0, addr} - {1'b0, base};
        lim = {1'b0, depth_words} << 2;
        return (addr >= base) && (off < lim);
    endfunction

endpackage

// File: rtl/sram_axil_array.sv
// Word storage: synchronous read with registered output, byte-enabled write, old data on collision.
module sram_axil_array #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS),
    localparam int unsigned STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rd_en,
    input  logic                  i_rd_zero,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [STRB_W-1:0]     i_wr_strb
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Byte-strobed write; contents are never reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read register; a zero request covers out-of-window reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_zero ? '0 : r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sram_axil_slave.sv
// AXI-lite SRAM responder with independent read/write FSMs and programmable latencies.
module sram_axil_slave
    import sram_axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned WR_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam int unsigned LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    rd_state_e             r_rstate, w_rstate_nxt;
    logic [CNT_W-1:0]      r_rcnt, w_rcnt_nxt;
    logic [ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
    logic                  r_arready, w_arready_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    logic [1:0]            r_rresp, w_rresp_nxt;
    logic                  w_rd_en, w_rd_ok;
    logic [IDX_W-1:0]      w_rd_idx;

    wr_state_e             r_wstate, w_wstate_nxt;
    logic [CNT_W-1:0]      r_wcnt, w_wcnt_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
    wr_payload_t           r_wpay, w_wpay_nxt;
    logic                  r_aw_held, w_aw_held_nxt;
    logic                  r_w_held, w_w_held_nxt;
    logic                  r_awready, w_awready_nxt;
    logic                  r_wready, w_wready_nxt;
    logic                  r_bvalid, w_bvalid_nxt;
    logic [1:0]            r_bresp, w_bresp_nxt;
    logic                  w_aw_take, w_w_take, w_wr_en, w_wr_ok;
    logic [IDX_W-1:0]      w_wr_idx;

    assign w_rd_ok  = in_range(32'(r_araddr), BASE_ADDR, 32'(DEPTH_WORDS));
    assign w_wr_ok  = in_range(32'(r_awaddr), BASE_ADDR, 32'(DEPTH_WORDS));
    assign w_rd_idx = IDX_W'(to_word_idx(32'(r_araddr), BASE_ADDR));
    assign w_wr_idx = IDX_W'(to_word_idx(32'(r_awaddr), BASE_ADDR));

    // Read FSM next state; counter loaded with RD_LATENCY-1 so rvalid rises RD_LATENCY edges after AR
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_rcnt_nxt    = r_rcnt;
        w_araddr_nxt  = r_araddr;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rresp_nxt   = r_rresp;
        w_rd_en       = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (arvalid && r_arready) begin
                    w_araddr_nxt  = araddr;
                    w_rcnt_nxt    = CNT_W'(RD_LATENCY - 1);
                    w_arready_nxt = 1'b0;
                    w_rstate_nxt  = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_rcnt == '0) begin
                    w_rd_en      = 1'b1;
                    w_rresp_nxt  = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                    w_rvalid_nxt = 1'b1;
                    w_rstate_nxt = R_RESP;
                end else begin
                    w_rcnt_nxt = r_rcnt - CNT_W'(1);
                end
            end
            R_RESP: begin
                if (rready) begin
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                    w_rstate_nxt  = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Write FSM next state; AW and W held independently, commit once both are present
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_wcnt_nxt    = r_wcnt;
        w_awaddr_nxt  = r_awaddr;
        w_wpay_nxt    = r_wpay;
        w_aw_held_nxt = r_aw_held;
        w_w_held_nxt  = r_w_held;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_aw_take     = 1'b0;
        w_w_take      = 1'b0;
        w_wr_en       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_aw_take = awvalid && r_awready;
                w_w_take  = wvalid && r_wready;
                if (w_aw_take) begin
                    w_awaddr_nxt  = awaddr;
                    w_aw_held_nxt = 1'b1;
                    w_awready_nxt = 1'b0;
                end
                if (w_w_take) begin
                    w_wpay_nxt.data = wdata;
                    w_wpay_nxt.strb = wstrb;
                    w_w_held_nxt    = 1'b1;
                    w_wready_nxt    = 1'b0;
                end
                if ((r_aw_held || w_aw_take) && (r_w_held || w_w_take)) begin
                    w_wcnt_nxt   = CNT_W'(WR_LATENCY - 1);
                    w_wstate_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                if (r_wcnt == '0) begin
                    w_wr_en      = w_wr_ok;
                    w_bresp_nxt  = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                    w_bvalid_nxt = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else begin
                    w_wcnt_nxt = r_wcnt - CNT_W'(1);
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_bvalid_nxt  = 1'b0;
                    w_aw_held_nxt = 1'b0;
                    w_w_held_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                    w_wstate_nxt  = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // State and output registers for both channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_rcnt    <= '0;
            r_araddr  <= '0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_wstate  <= W_IDLE;
            r_wcnt    <= '0;
            r_awaddr  <= '0;
            r_wpay    <= '0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_araddr  <= w_araddr_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rresp   <= w_rresp_nxt;
            r_wstate  <= w_wstate_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wpay    <= w_wpay_nxt;
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
        end
    end

    sram_axil_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_en   (w_rd_en),
        .i_rd_zero (~w_rd_ok),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (rdata),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (r_wpay.data),
        .i_wr_strb (r_wpay.strb)
    );

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rresp   = r_rresp;
    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;

endmodule

// File: tb/tb_sram_axil_slave.sv
// Self-checking bench for sram_axil_slave against a word-array reference model.
module tb_sram_axil_slave;

    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned WR_LAT = 2;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic        clk, rst_n;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    bit [31:0] ref_mem [int];

    sram_axil_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
        .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a word array addressed by (addr-BASE)/4 inside the window
    function automatic bit m_in_range(input logic [31:0] a);
        longint av, lo;
        av = longint'({32'b0, a});
        lo = longint'({32'b0, BASE});
        return (av >= lo) && (av < lo + 4 * longint'(DEPTH));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((longint'({32'b0, a}) - longint'({32'b0, BASE})) / 4);
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit [31:0] w;
        if (!m_in_range(a)) return;
        w = ref_mem.exists(m_idx(a)) ? ref_mem[m_idx(a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[m_idx(a)] = w;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_in_range(a)) return 32'h0;
        return ref_mem.exists(m_idx(a)) ? ref_mem[m_idx(a)] : 32'h0;
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return m_in_range(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] word_addr(input int idx);
        return BASE + 32'(idx) * 32'd4;
    endfunction

    // Bus driver: full read transaction, reports latency from AR handshake edge to rvalid
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output bit ar_dropped, output bit ok);
        bit hs;
        int c;
        ok = 1'b1; lat = 0; data = '0; resp = '0; ar_dropped = 1'b0;
        araddr = addr; arvalid = 1'b1; c = 0;
        do begin
            hs = arready;
            @(posedge clk); #1; c++;
        end while (!hs && c < 50);
        arvalid = 1'b0;
        if (!hs) begin ok = 1'b0; return; end
        ar_dropped = !arready;
        while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!rvalid) begin ok = 1'b0; return; end
        data = rdata; resp = rresp;
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
    endtask

    // Bus driver: AW and W raised after their own cycle delays; latency from later handshake to bvalid
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, output logic [1:0] resp,
                            output int lat, output bit ok);
        bit aw_done, w_done, aw_hs, w_hs;
        int c;
        ok = 1'b1; lat = 0; resp = '0; aw_done = 1'b0; w_done = 1'b0; c = 0;
        while (!(aw_done && w_done)) begin
            if (c == aw_dly) begin awaddr = addr; awvalid = 1'b1; end
            if (c == w_dly)  begin wdata = data; wstrb = strb; wvalid = 1'b1; end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1'b1;  wvalid = 1'b0; end
            c++;
            if (c > 100) begin ok = 1'b0; awvalid = 1'b0; wvalid = 1'b0; return; end
        end
        while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!bvalid) begin ok = 1'b0; return; end
        resp = bresp;
        bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({arready, awready, wready} !== 3'b111) $display("FAIL reset_readies: got %b want 111", {arready, awready, wready});
        else n_pass++;
        n_checks++;
        if ({rvalid, bvalid} !== 2'b00) $display("FAIL reset_valids: got %b want 00", {rvalid, bvalid});
        else n_pass++;
        n_checks++;
        if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00)
            $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b want 0/00/00", rdata, rresp, bresp);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_latency();
        logic [31:0] d, a; logic [1:0] r; int lat; bit ok, drop;
        a = 32'h8000_0010;
        d = $urandom;
        do_write(a, d, 4'hF, 0, 0, r, lat, ok);
        m_write(a, d, 4'hF);
        do_read(a, d, r, lat, drop, ok);
        n_checks++;
        if (!ok || lat != int'(RD_LAT)) $display("FAIL read_latency: ok=%0d got %0d want %0d", ok, lat, RD_LAT);
        else n_pass++;
        n_checks++;
        if (!drop) $display("FAIL read_arready_drop: got arready=1 after AR, want 0");
        else n_pass++;
        n_checks++;
        if (d !== m_read(a) || r !== 2'b00) $display("FAIL read_data: got %h/%b want %h/00", d, r, m_read(a));
        else n_pass++;
    endtask

    task automatic test_strobe_w_first();
        logic [31:0] d, a; logic [1:0] r; int lat; bit ok, drop;
        a = 32'h8000_0020;
        do_write(a, 32'h1122_3344, 4'hF, 0, 0, r, lat, ok);
        m_write(a, 32'h1122_3344, 4'hF);
        do_write(a, 32'hDEAD_BEEF, 4'b0110, 2, 0, r, lat, ok);
        m_write(a, 32'hDEAD_BEEF, 4'b0110);
        n_checks++;
        if (!ok || r !== 2'b00 || lat != int'(WR_LAT))
            $display("FAIL strobe_bresp: ok=%0d bresp=%b lat=%0d want 00 lat %0d", ok, r, lat, WR_LAT);
        else n_pass++;
        do_read(a, d, r, lat, drop, ok);
        n_checks++;
        if (!ok || d !== 32'h11AD_BE44 || d !== m_read(a))
            $display("FAIL strobe_readback: got %h want %h", d, 32'h11AD_BE44);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] a, exp_d; int lat; bit bad;
        a = word_addr(int'($urandom_range(0, DEPTH - 1)));
        exp_d = $urandom;
        begin
            logic [1:0] r; bit ok;
            do_write(a, exp_d, 4'hF, 1, 0, r, lat, ok);
        end
        m_write(a, exp_d, 4'hF);
        araddr = a; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== m_read(a) || rresp !== 2'b00 || arready !== 1'b0) begin
                $display("FAIL stall_cycle%0d: rvalid=%b rdata=%h rresp=%b arready=%b want 1/%h/00/0",
                         i, rvalid, rdata, rresp, arready, m_read(a));
                bad = 1'b1;
            end else n_pass++;
            if (i < 5) begin @(posedge clk); #1; end
        end
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
        n_checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) $display("FAIL stall_release: rvalid=%b arready=%b want 0/1", rvalid, arready);
        else n_pass++;
    endtask

    task automatic test_same_edge();
        logic [31:0] a, old_d, new_d, rd1, rd2; logic [1:0] rr, wr; int rl, wl; bit rok, wok, drop;
        a = word_addr(int'($urandom_range(0, DEPTH - 1)));
        old_d = $urandom;
        new_d = ~old_d;
        do_write(a, old_d, 4'hF, 0, 0, wr, wl, wok);
        m_write(a, old_d, 4'hF);
        // Read handshakes one edge before the write's; RD_LAT=WR_LAT+1 aligns sample and commit
        fork
            do_read(a, rd1, rr, rl, drop, rok);
            do_write(a, new_d, 4'hF, 1, 1, wr, wl, wok);
        join
        n_checks++;
        if (!rok || rd1 !== old_d) $display("FAIL same_edge_old: got %h want %h", rd1, old_d);
        else n_pass++;
        m_write(a, new_d, 4'hF);
        do_read(a, rd2, rr, rl, drop, rok);
        n_checks++;
        if (!rok || rd2 !== m_read(a)) $display("FAIL same_edge_new: got %h want %h", rd2, m_read(a));
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d, a_lo, a_hi; logic [1:0] r; int lat; bit ok, drop;
        a_lo = word_addr(0);
        a_hi = word_addr(int'(DEPTH) - 1);
        do_write(a_lo, 32'hA5A5_0001, 4'hF, 0, 0, r, lat, ok);
        m_write(a_lo, 32'hA5A5_0001, 4'hF);
        do_write(a_hi, 32'h5A5A_0002, 4'hF, 0, 0, r, lat, ok);
        m_write(a_hi, 32'h5A5A_0002, 4'hF);
        do_read(32'h7FFF_FFFC, d, r, lat, drop, ok);
        n_checks++;
        if (!ok || r !== 2'b10 || d !== 32'h0) $display("FAIL oor_read: got %h/%b want 00000000/10", d, r);
        else n_pass++;
        do_write(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 0, 0, r, lat, ok);
        m_write(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF);
        n_checks++;
        if (!ok || r !== m_resp(BASE + 32'(4 * DEPTH))) $display("FAIL oor_bresp: got %b want 10", r);
        else n_pass++;
        do_read(a_lo, d, r, lat, drop, ok);
        n_checks++;
        if (!ok || d !== m_read(a_lo) || r !== 2'b00) $display("FAIL oor_word0: got %h/%b want %h/00", d, r, m_read(a_lo));
        else n_pass++;
        do_read(a_hi, d, r, lat, drop, ok);
        n_checks++;
        if (!ok || d !== m_read(a_hi) || r !== 2'b00) $display("FAIL oor_lastword: got %h/%b want %h/00", d, r, m_read(a_hi));
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] a, d; logic [1:0] r; int lat; bit ok, drop, seen;
        a = word_addr(int'($urandom_range(0, DEPTH - 1)));
        do_write(a, 32'h0BAD_F00D, 4'hF, 0, 0, r, lat, ok);
        m_write(a, 32'h0BAD_F00D, 4'hF);
        araddr = a; arvalid = 1'b1;
        awaddr = a; awvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rvalid, bvalid, arready, awready, wready} !== 5'b00111)
            $display("FAIL abort_immediate: rv/bv/ar/aw/w=%b want 00111", {rvalid, bvalid, arready, awready, wready});
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bvalid || rvalid || !awready) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen) $display("FAIL abort_w_alone: got bvalid/rvalid or awready low, want none");
        else n_pass++;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(a, d, r, lat, drop, ok);
        n_checks++;
        if (!ok || d !== m_read(a)) $display("FAIL abort_storage: got %h want %h", d, m_read(a));
        else n_pass++;
    endtask

    task automatic test_random();
        int idxq[$];
        logic [31:0] a, d; logic [3:0] s; logic [1:0] r; int lat; bit ok, drop;
        for (int i = 0; i < 8; i++) begin
            idxq.push_back(int'($urandom_range(0, DEPTH - 1)));
            a = word_addr(idxq[i]);
            d = $urandom;
            do_write(a, d, 4'hF, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r, lat, ok);
            m_write(a, d, 4'hF);
        end
        for (int i = 0; i < 16; i++) begin
            a = word_addr(idxq[$urandom_range(0, 7)]) + 32'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r, lat, ok);
            m_write(a, d, s);
            n_checks++;
            if (!ok || r !== m_resp(a) || lat != int'(WR_LAT))
                $display("FAIL rand_write%0d: ok=%0d bresp=%b lat=%0d want %b lat %0d", i, ok, r, lat, m_resp(a), WR_LAT);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            a = word_addr(idxq[i]) + 32'($urandom_range(0, 3));
            do_read(a, d, r, lat, drop, ok);
            n_checks++;
            if (!ok || d !== m_read(a) || r !== 2'b00 || lat != int'(RD_LAT))
                $display("FAIL rand_read%0d: got %h/%b lat %0d want %h/00 lat %0d", i, d, r, lat, m_read(a), RD_LAT);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        test_reset();
        test_read_latency();
        test_strobe_w_first();
        test_stall();
        test_same_edge();
        test_out_of_range();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
